// File: rtl/seq1001_mealy_nonovl_pkg.sv
// Shared constants for the 1001 Mealy detector: default pattern, state width
// and binary state encodings.
package seq1001_mealy_nonovl_pkg;

    localparam int PAT_LEN = 4;
    localparam logic [PAT_LEN-1:0] PATTERN = 4'b1001;
    localparam int STATE_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    typedef logic [STATE_W-1:0] state_t;

    // Sk means the last k sampled bits match the first k pattern bits
    localparam state_t S0 = 2'd0;
    localparam state_t S1 = 2'd1;
    localparam state_t S2 = 2'd2;
    localparam state_t S3 = 2'd3;

endpackage

// File: rtl/seq1001_mealy_nonovl_if.sv
// Serial data in / detect flag out between the input stage (master) and the
// detector (slave).
interface seq1001_mealy_nonovl_if;

    logic ser_in;
    logic out;

    modport master (output ser_in, input out);
    modport slave (input ser_in, output out);

endinterface

// File: rtl/seq1001_mealy_nonovl.sv
// Non-overlapping Mealy sequence detector; out is combinational from the state
// register and the live serial bit, so it flags the final bit in its own cycle.
module seq1001_mealy_nonovl
    import seq1001_mealy_nonovl_pkg::*;
#(
    parameter int PAT_LEN_P = PAT_LEN,
    parameter logic [PAT_LEN_P-1:0] PATTERN_P = PATTERN
) (
    input  logic clk,
    input  logic rst,
    seq1001_mealy_nonovl_if.slave bus
);

    localparam int SW = (PAT_LEN_P > 1) ? $clog2(PAT_LEN_P) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(PAT_LEN_P - 1);

    typedef logic [2*PAT_LEN_P-1:0][SW-1:0] next_tbl_t;

    // Entry {k, b}: longest suffix of (prefix_k + b) that is itself a pattern
    // prefix; a completed match returns to zero so bits are never reused.
    function automatic next_tbl_t build_table();
        next_tbl_t tbl;
        int best;
        int p;
        logic match;
        logic s_bit;
        tbl = '0;
        for (int k = 0; k < PAT_LEN_P; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                if (!(k == PAT_LEN_P - 1 && b[0] == PATTERN_P[0])) begin
                    for (int j = 1; j <= k + 1; j++) begin
                        match = 1'b1;
                        for (int q = 0; q < j; q++) begin
                            p = k + 1 - j + q;
                            s_bit = (p < k) ? PATTERN_P[PAT_LEN_P-1-p] : b[0];
                            if (s_bit != PATTERN_P[PAT_LEN_P-1-q]) begin
                                match = 1'b0;
                            end
                        end
                        if (match) begin
                            best = j;
                        end
                    end
                end
                tbl[k*2+b] = SW'(best);
            end
        end
        return tbl;
    endfunction

    localparam next_tbl_t NEXT_TABLE = build_table();

    logic [SW-1:0] state;
    logic [SW-1:0] next_state;
    logic          state_legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
        end else begin
            state <= next_state;
        end
    end

    // Unused encodings (only possible when PAT_LEN is not a power of two) fall back to S0
    always_comb begin
        next_state  = '0;
        state_legal = ({1'b0, state} < (SW+1)'(PAT_LEN_P));
        if (state_legal) begin
            next_state = NEXT_TABLE[{state, bus.ser_in}];
        end
        bus.out = rst && (state == S_LAST) && (bus.ser_in == PATTERN_P[0]);
    end

endmodule

// File: tb/tb_seq1001_mealy_nonovl.sv
// Directed bench for the 1001 detector: reset hold, detection timing,
// non-overlap restart, fallback on repeated 1s and asynchronous reset mid-match.
module tb_seq1001_mealy_nonovl;
    import seq1001_mealy_nonovl_pkg::*;

    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;

    seq1001_mealy_nonovl_if bus ();

    seq1001_mealy_nonovl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input logic expected, input string tag);
        check_count++;
        assert (bus.out === expected) pass_count++;
        else $error("[TB] FAIL %s: out=%b expected %b at t=%0t", tag, bus.out, expected, $time);
    endtask

    task automatic check_state(input state_t expected, input string tag);
        check_count++;
        assert (dut.state === expected) pass_count++;
        else $error("[TB] FAIL %s: state=%0d expected %0d at t=%0t", tag, dut.state, expected, $time);
    endtask

    // Drives one bit for a full 10-unit interval and checks out 2 units in
    task automatic apply_stimulus(input logic b, input logic expected, input string tag);
        bus.ser_in = b;
        #2;
        check_output(expected, tag);
        #8;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst         = 1'b0;
        bus.ser_in  = 1'b1;
        #2;  check_output(1'b0, "rst_hold_a");
        #6;  check_output(1'b0, "rst_hold_b");
        #2;  bus.ser_in = 1'b0;
        #2;  check_output(1'b0, "rst_hold_c");
        #3;  rst = 1'b1;
        #2;  check_state(S0, "post_reset_state");
        #3;

        // t=20: stream 0,1,0,0,1 -> detect while the final 1 is present
        apply_stimulus(1'b0, 1'b0, "s20");
        apply_stimulus(1'b1, 1'b0, "s30");
        apply_stimulus(1'b0, 1'b0, "s40");
        apply_stimulus(1'b0, 1'b0, "s50");
        apply_stimulus(1'b1, 1'b1, "detect_65");
        check_state(S0, "restart_after_65");

        // Non-overlap: the trailing 1 of the previous match is not reused
        apply_stimulus(1'b0, 1'b0, "s70");
        apply_stimulus(1'b0, 1'b0, "s80");
        apply_stimulus(1'b1, 1'b0, "no_detect_95");
        apply_stimulus(1'b0, 1'b0, "s100");
        apply_stimulus(1'b0, 1'b0, "s110");
        apply_stimulus(1'b1, 1'b1, "detect_125");
        check_state(S0, "restart_after_125");

        // Three zeros then 1 after a detection
        apply_stimulus(1'b0, 1'b0, "s130");
        apply_stimulus(1'b0, 1'b0, "s140");
        apply_stimulus(1'b0, 1'b0, "s150");
        apply_stimulus(1'b1, 1'b0, "no_detect_165");
        apply_stimulus(1'b0, 1'b0, "s170");
        apply_stimulus(1'b0, 1'b0, "s180");
        apply_stimulus(1'b1, 1'b1, "detect_195");

        // Fallback: 1,1,0,0,1 stays in S1 on the repeated 1
        apply_stimulus(1'b1, 1'b0, "s200");
        apply_stimulus(1'b1, 1'b0, "s1_loop_210");
        check_state(S1, "s1_after_215");
        apply_stimulus(1'b0, 1'b0, "s220");
        apply_stimulus(1'b0, 1'b0, "s230");
        apply_stimulus(1'b1, 1'b1, "fallback_detect_245");

        // Reach S3, then drop reset between edges with ser_in high
        apply_stimulus(1'b1, 1'b0, "s250");
        apply_stimulus(1'b0, 1'b0, "s260");
        apply_stimulus(1'b0, 1'b0, "s270");
        check_state(S3, "s3_reached");
        bus.ser_in = 1'b1;
        #1;  check_output(1'b1, "s3_live_detect");
        #1;  rst = 1'b0;
        #1;  check_output(1'b0, "async_reset_out");
        check_state(S0, "async_reset_state");
        #5;  rst = 1'b1;
        #2;

        // A lone 1 after reset release must not detect
        apply_stimulus(1'b1, 1'b0, "lone_one_295");
        check_state(S1, "s1_after_295");
        apply_stimulus(1'b0, 1'b0, "s300");
        check_state(S2, "s2_after_305");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
